apb_slave_mem: RTL and testbench

- APB completer (slave) that terminates the APB side of the AHB-to-APB bridge.
- Responds to the bridge's Paddr/Pwdata/Pwrite/Pselx/Penable with Prdata, Pready and Pslverr.
- Backed by a word-addressed RAM with programmable wait states, a protocol checker and transfer counters.
- Serves as the APB-side responder in the class testbench and as a reusable peripheral model.

---
 rtl/apb_slave_mem.sv | 168 ++++++++++++++++
 tb/tb_apb_slave_mem.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed RAM, with programmable wait states,
// a sticky protocol checker and saturating good-transfer counters.
module apb_slave_mem #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                SEL_W       = 3,
    parameter int                SEL_IDX     = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int                DEPTH       = 256,
    parameter int                WAIT_STATES = 0
) (
    input  logic              Pclk,
    input  logic              Preset,
    input  logic [ADDR_W-1:0] Paddr,
    input  logic [DATA_W-1:0] Pwdata,
    input  logic              Pwrite,
    input  logic [SEL_W-1:0]  Pselx,
    input  logic              Penable,
    output logic [DATA_W-1:0] Prdata,
    output logic              Pready,
    output logic              Pslverr,
    output logic              proto_err,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
);
    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            r_state, w_state_next, w_phase;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_write;
    logic [IDX_W-1:0]  r_idx;
    logic              r_in_range;
    logic [3:0]        r_wait;
    logic              r_ready;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic              r_proto;
    logic [15:0]       r_wr_cnt;
    logic [15:0]       r_rd_cnt;

    logic              w_sel;
    logic [ADDR_W-1:0] w_offset;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;
    logic              w_violation;
    logic              w_complete;
    logic              w_idle_err;
    logic              w_unused;

    assign w_sel      = Pselx[SEL_IDX];
    assign w_offset   = Paddr - BASE_ADDR;
    assign w_in_range = (Paddr >= BASE_ADDR) && (w_offset < SPAN);
    assign w_idx      = w_offset[IDX_W+1:2];
    assign w_unused   = ^Pselx;

    // The bus setup cycle is recognised combinationally from IDLE, so the
    // SETUP phase coincides with the APB setup cycle and back-to-back
    // transfers need no gap after completion.
    always_comb begin
        w_phase      = r_state;
        w_state_next = IDLE;
        w_violation  = 1'b0;
        w_complete   = 1'b0;
        w_idle_err   = 1'b0;
        if (r_state == IDLE && w_sel && !Penable) begin
            w_phase = SETUP;
        end
        case (w_phase)
            IDLE: begin
                w_idle_err   = w_sel && Penable;
                w_state_next = IDLE;
            end
            SETUP: begin
                w_state_next = ACCESS;
            end
            ACCESS: begin
                w_violation  = !w_sel || !Penable || (Paddr != r_addr) ||
                               (Pwrite != r_write) || (Pwdata != r_wdata);
                w_complete   = !w_violation && r_ready;
                w_state_next = (w_violation || w_complete) ? IDLE : ACCESS;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Pclk or posedge Preset) begin
        if (Preset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_write    <= 1'b0;
            r_idx      <= '0;
            r_in_range <= 1'b0;
            r_wait     <= '0;
            r_ready    <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_proto    <= 1'b0;
            r_wr_cnt   <= '0;
            r_rd_cnt   <= '0;
        end else begin
            if (w_phase == SETUP) begin
                r_addr     <= Paddr;
                r_wdata    <= Pwdata;
                r_write    <= Pwrite;
                r_idx      <= w_idx;
                r_in_range <= w_in_range;
                r_wait     <= 4'(WAIT_STATES);
                r_ready    <= (WAIT_STATES == 0);
                r_err      <= !w_in_range;
                if (!Pwrite) begin
                    r_rdata <= w_in_range ? r_mem[w_idx] : '0;
                end else if (!w_in_range) begin
                    r_rdata <= '0;
                end
            end else if (w_phase == ACCESS) begin
                if (w_violation) begin
                    r_proto <= 1'b1;
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                end else if (r_ready) begin
                    r_ready <= 1'b0;
                    r_err   <= 1'b0;
                    if (r_in_range && r_write && r_wr_cnt != 16'hFFFF) begin
                        r_wr_cnt <= r_wr_cnt + 16'd1;
                    end
                    if (r_in_range && !r_write && r_rd_cnt != 16'hFFFF) begin
                        r_rd_cnt <= r_rd_cnt + 16'd1;
                    end
                end else begin
                    // Ready is raised one cycle early so it is seen as the counter hits 0.
                    if (r_wait <= 4'd1) begin
                        r_ready <= 1'b1;
                    end
                    r_wait <= r_wait - 4'd1;
                end
            end
            if (w_idle_err) begin
                r_proto <= 1'b1;
            end
        end
    end

    always_ff @(posedge Pclk) begin
        if (w_complete && r_write && r_in_range) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign Prdata    = r_rdata;
    assign Pready    = r_ready;
    assign Pslverr   = r_err;
    assign proto_err = r_proto;
    assign wr_count  = r_wr_cnt;
    assign rd_count  = r_rd_cnt;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (0 and 3 wait states) on a shared bus,
// expected responses queued at drive time and compared at completion.
module tb_apb_slave_mem;
    logic        Pclk = 1'b0;
    logic        Preset;
    logic [31:0] Paddr, Pwdata;
    logic        Pwrite, Penable;
    logic [2:0]  Pselx;

    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1, proto0, proto1;
    logic [15:0] wrc0, wrc1, rdc0, rdc1;

    always #5 Pclk = ~Pclk;

    apb_slave_mem #(.WAIT_STATES(0), .SEL_IDX(0)) u_dut0 (
        .Pclk(Pclk), .Preset(Preset), .Paddr(Paddr), .Pwdata(Pwdata),
        .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable),
        .Prdata(prdata0), .Pready(pready0), .Pslverr(pslverr0),
        .proto_err(proto0), .wr_count(wrc0), .rd_count(rdc0)
    );

    apb_slave_mem #(.WAIT_STATES(3), .SEL_IDX(1)) u_dut1 (
        .Pclk(Pclk), .Preset(Preset), .Paddr(Paddr), .Pwdata(Pwdata),
        .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable),
        .Prdata(prdata1), .Pready(pready1), .Pslverr(pslverr1),
        .proto_err(proto1), .wr_count(wrc1), .rd_count(rdc1)
    );

    typedef struct {
        logic        is_rd;
        logic        err;
        logic [31:0] data;
        int          ws;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [logic [32:0]];
    int          exp_wr [2];
    int          exp_rd [2];
    logic        exp_proto [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f_rdata(input int d);
        return (d != 0) ? prdata1 : prdata0;
    endfunction
    function automatic logic f_ready(input int d);
        return (d != 0) ? pready1 : pready0;
    endfunction
    function automatic logic f_err(input int d);
        return (d != 0) ? pslverr1 : pslverr0;
    endfunction
    function automatic logic f_in_range(input logic [31:0] a);
        return (a >= 32'h8000_0000) && (a < 32'h8000_0400);
    endfunction

    task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        exp_t        e;
        exp_t        got_e;
        logic [32:0] key;
        int          waits;
        bit          done;
        key     = {d[0], addr & 32'hFFFF_FFFC};
        e.is_rd = !wr;
        e.err   = !f_in_range(addr);
        e.ws    = (d != 0) ? 3 : 0;
        e.data  = 32'h0;
        if (!e.err) begin
            if (wr) begin
                model[key] = wd;
                exp_wr[d]++;
            end else begin
                e.data = model.exists(key) ? model[key] : 32'h0;
                exp_rd[d]++;
            end
        end
        exp_q.push_back(e);
        $display("xfer dut%0d %s addr=%h wdata=%h", d, wr ? "WR" : "RD", addr, wd);
        @(posedge Pclk); #1;
        Pselx   = (d != 0) ? 3'b010 : 3'b001;
        Penable = 1'b0;
        Paddr   = addr;
        Pwrite  = wr;
        Pwdata  = wd;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done && waits <= 20) begin
            @(negedge Pclk);
            if (f_ready(d)) done = 1'b1;
            else waits++;
        end
        got_e = exp_q.pop_front();
        if (!done) begin
            check("pready_timeout", 32'(done), 32'd1);
        end else begin
            check("wait_cycles", 32'(waits), 32'(got_e.ws));
            check("pslverr", 32'(f_err(d)), 32'(got_e.err));
            if (got_e.is_rd || got_e.err) check("prdata", f_rdata(d), got_e.data);
        end
    endtask

    task automatic bus_idle();
        @(posedge Pclk); #1;
        Pselx   = 3'b000;
        Penable = 1'b0;
    endtask

    task automatic check_counts(input int d);
        @(negedge Pclk);
        check("wr_count", 32'((d != 0) ? wrc1 : wrc0), 32'(exp_wr[d]));
        check("rd_count", 32'((d != 0) ? rdc1 : rdc0), 32'(exp_rd[d]));
        check("proto_err", 32'((d != 0) ? proto1 : proto0), 32'(exp_proto[d]));
        check("pready_idle", 32'(f_ready(d)), 32'd0);
    endtask

    initial begin
        Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
        Preset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_wr[i] = 0; exp_rd[i] = 0; exp_proto[i] = 1'b0;
        end
        repeat (3) @(posedge Pclk);
        @(negedge Pclk);
        for (int d = 0; d < 2; d++) begin
            check("rst_prdata", f_rdata(d), 32'h0);
            check("rst_pready", 32'(f_ready(d)), 32'd0);
            check("rst_pslverr", 32'(f_err(d)), 32'd0);
        end
        Preset = 1'b0;
        check_counts(0);
        check_counts(1);

        // zero wait states: write then read back
        xfer(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0);
        bus_idle();
        check_counts(0);

        // three wait states
        xfer(1, 1'b1, 32'h8000_0010, 32'h0123_4567);
        xfer(1, 1'b0, 32'h8000_0010, 32'h0);
        bus_idle();
        check_counts(1);

        // out-of-range write must not alias onto word 0
        xfer(0, 1'b1, 32'h8000_0000, 32'h1234_5678);
        bus_idle();
        xfer(0, 1'b1, 32'h8000_0400, 32'hCAFE_F00D);
        bus_idle();
        xfer(0, 1'b0, 32'h8000_0000, 32'h0);
        xfer(0, 1'b0, 32'h7FFF_FFFC, 32'h0);
        bus_idle();
        check_counts(0);

        // back-to-back writes, then back-to-back reads
        xfer(0, 1'b1, 32'h8000_0000, 32'h11);
        xfer(0, 1'b1, 32'h8000_0004, 32'h22);
        xfer(0, 1'b1, 32'h8000_0008, 32'h33);
        bus_idle();
        check_counts(0);
        xfer(0, 1'b0, 32'h8000_0000, 32'h0);
        xfer(0, 1'b0, 32'h8000_0004, 32'h0);
        xfer(0, 1'b0, 32'h8000_0008, 32'h0);
        xfer(0, 1'b0, 32'h8000_03FC, 32'h0);
        bus_idle();
        check_counts(0);

        // Penable asserted while idle
        @(posedge Pclk); #1;
        Pselx = 3'b001; Penable = 1'b1; Paddr = 32'h8000_0000; Pwrite = 1'b0;
        @(posedge Pclk); #1;
        Pselx = 3'b000; Penable = 1'b0;
        exp_proto[0] = 1'b1;
        $display("xfer dut0 Penable-in-IDLE");
        check_counts(0);

        // address changes mid-access on the wait-state instance
        xfer(1, 1'b1, 32'h8000_0030, 32'h55);
        bus_idle();
        $display("xfer dut1 WR addr=80000030 aborted by address change");
        @(posedge Pclk); #1;
        Pselx = 3'b010; Penable = 1'b0; Paddr = 32'h8000_0030; Pwrite = 1'b1; Pwdata = 32'h99;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        @(negedge Pclk);
        check("abort_pready", 32'(pready1), 32'd0);
        check("abort_proto_before", 32'(proto1), 32'd0);
        @(posedge Pclk); #1;
        Paddr = 32'h8000_0034;
        @(posedge Pclk); #1;
        check("abort_proto_after", 32'(proto1), 32'd1);
        Pselx = 3'b000; Penable = 1'b0;
        exp_proto[1] = 1'b1;
        repeat (8) @(posedge Pclk);
        check_counts(1);
        xfer(1, 1'b0, 32'h8000_0030, 32'h0);
        bus_idle();
        check_counts(1);

        // reset asserted in the access cycle of a write
        xfer(0, 1'b1, 32'h8000_0020, 32'h0BAD_F00D);
        bus_idle();
        $display("xfer dut0 WR addr=80000020 interrupted by reset");
        @(posedge Pclk); #1;
        Pselx = 3'b001; Penable = 1'b0; Paddr = 32'h8000_0020; Pwrite = 1'b1; Pwdata = 32'hFFFF_FFFF;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        #1;
        check("pre_reset_pready", 32'(pready0), 32'd1);
        #1;
        Preset = 1'b1;
        #1;
        check("async_pready", 32'(pready0), 32'd0);
        check("async_prdata", prdata0, 32'h0);
        check("async_proto0", 32'(proto0), 32'd0);
        check("async_proto1", 32'(proto1), 32'd0);
        check("async_wr_count", 32'(wrc0), 32'd0);
        @(negedge Pclk);
        Preset = 1'b0;
        Pselx = 3'b000; Penable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_wr[i] = 0; exp_rd[i] = 0; exp_proto[i] = 1'b0;
        end
        xfer(0, 1'b0, 32'h8000_0020, 32'h0);
        bus_idle();
        check_counts(0);
        check_counts(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
